// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory fetch port.
//   req    fetch request valid, held with addr until gnt
//   addr   word-aligned fetch address
//   gnt    request accepted this cycle
//   rvalid response valid; responses return in request order
//   rdata  response instruction word
// master = fetch unit side, slave = instruction memory side.
interface fetch_prefetch_queue_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch stage feeding decode. Issues in-order word fetches
// over the imem port, buffers returned words with their PCs in a DEPTH-entry
// FIFO and presents the head to decode. A taken branch flushes the FIFO,
// redirects fetch and drops every response still in flight.
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   taken_branch_i       flush + redirect to new_pc_i (low two bits ignored)
//   stall_i              decode cannot accept; head is held
//   imem                 fetch request/response port (master side)
//   valid_o/pc_o/instr_o FIFO head; pc_o=0 and instr_o=NOP_INSTR when empty
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          taken_branch_i,
    input  logic [31:0]                   new_pc_i,
    input  logic                          stall_i,
    fetch_prefetch_queue_if.master        imem,
    output logic                          valid_o,
    output logic [31:0]                   pc_o,
    output logic [31:0]                   instr_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    // stale: the pending request was issued before a flush; its response
    // must be dropped and it must not advance fetch_pc when granted
    logic          stale_q, stale_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];

    logic        flush, gnt, rv, drop, push, pop, pending;
    logic [31:0] target;
    logic [CW:0] occ_d;

    assign flush   = taken_branch_i;
    assign target  = new_pc_i & 32'hFFFF_FFFC;
    assign gnt     = req_q & imem.gnt;
    // a response with nothing outstanding is ignored (flagged below)
    assign rv      = imem.rvalid & (out_q != '0);
    assign drop    = rv & (disc_q != '0);
    assign push    = rv & ~drop & ~flush;
    assign pop     = valid_o & ~stall_i & ~flush;
    assign pending = req_q & ~imem.gnt;

    assign valid_o   = (cnt_q != '0);
    assign pc_o      = valid_o ? mem_pc_q[rd_ptr_q] : 32'h0;
    assign instr_o   = valid_o ? mem_instr_q[rd_ptr_q] : NOP_INSTR;
    assign imem.req  = req_q;
    assign imem.addr = addr_q;

    always_comb begin
        out_d = out_q + CW'(gnt) - CW'(rv);

        cnt_d = cnt_q;
        if (flush)             cnt_d = '0;
        else if (push && !pop) cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);

        // on flush everything still in flight (incl. a grant this cycle)
        // becomes garbage; a stale request granted later is added then
        if (flush) disc_d = out_d;
        else       disc_d = disc_q - CW'(drop) + CW'(gnt & stale_q);

        if (flush)    stale_d = pending;
        else if (gnt) stale_d = 1'b0;
        else          stale_d = stale_q;

        if (flush)                fetch_pc_d = target;
        else if (gnt && !stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
        else                      fetch_pc_d = fetch_pc_q;

        if (flush)     rsp_pc_d = target;
        else if (push) rsp_pc_d = rsp_pc_q + 32'd4;
        else           rsp_pc_d = rsp_pc_q;

        // credit: every outstanding fetch has a FIFO slot reserved
        occ_d  = {1'b0, cnt_d} + {1'b0, out_d};
        req_d  = pending | (occ_d < (CW+1)'(DEPTH));
        addr_d = pending ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            stale_q    <= 1'b0;
            cnt_q      <= '0;
            out_q      <= '0;
            disc_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            stale_q    <= stale_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // storage needs no reset: only entries below cnt_q are ever read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
            mem_instr_q[wr_ptr_q] <= imem.rdata;
        end
    end

    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rstn_i)
        imem.rvalid |-> (out_q != '0));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
        cnt_q <= CW'(DEPTH));
    a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rstn_i)
        imem.addr[1:0] == 2'b00);
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        taken_branch;
    logic        stall;
    logic [31:0] new_pc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;

    fetch_prefetch_queue_if imem_if();

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .taken_branch_i (taken_branch),
        .new_pc_i       (new_pc),
        .stall_i        (stall),
        .imem           (imem_if),
        .valid_o        (valid),
        .pc_o           (pc),
        .instr_o        (instr)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    logic rsp_en;
    logic [31:0] rq[$];   // granted addresses awaiting response, in order

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        rsp;
        logic        ev;
        logic [31:0] epc;
        logic        er;
        logic [31:0] ea;
    } vec_t;
    vec_t tbl [22];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic drive_rsp();
        imem_if.rvalid = rsp_en && (rq.size() > 0);
        imem_if.rdata  = (rq.size() > 0 && imem_if.rvalid) ? memf(rq[0]) : 32'h0;
    endtask

    task automatic step();
        logic g;
        logic [31:0] a;
        g = imem_if.req && imem_if.gnt;
        a = imem_if.addr;
        if (imem_if.rvalid) void'(rq.pop_front());
        if (g) rq.push_back(a);
        @(posedge clk);
        #1;
        drive_rsp();
    endtask

    task automatic check(input string nm, input logic ev, input logic [31:0] epc,
                         input logic er, input logic [31:0] ea);
        logic [31:0] xpc, xin;
        xpc = ev ? epc : 32'h0;
        xin = ev ? memf(epc) : NOP;
        nvec++;
        if (valid !== ev || pc !== xpc || instr !== xin ||
            imem_if.req !== er || imem_if.addr !== ea) begin
            nmis++;
            $display("FAIL %s: got v=%0b pc=%h instr=%h req=%0b addr=%h, want v=%0b pc=%h instr=%h req=%0b addr=%h",
                     nm, valid, pc, instr, imem_if.req, imem_if.addr, ev, xpc, xin, er, ea);
        end
    endtask

    task automatic row(input string nm, input logic s, input logic g, input logic r,
                       input logic f, input logic [31:0] np, input logic ev,
                       input logic [31:0] epc, input logic er, input logic [31:0] ea);
        stall        = s;
        imem_if.gnt  = g;
        rsp_en       = r;
        taken_branch = f;
        new_pc       = np;
        drive_rsp();
        check(nm, ev, epc, er, ea);
        step();
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        stall        = 1'b0;
        taken_branch = 1'b0;
        new_pc       = 32'h0;
        imem_if.gnt  = 1'b0;
        rsp_en       = 1'b0;
        rq.delete();
        drive_rsp();
        @(posedge clk);
        #1;
        check("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        // streaming from reset, then a 10-cycle stall (cycles 5..14)
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd4};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd0,  1'b1, 32'd8};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd4,  1'b1, 32'd12};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd16};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd20};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd8,  1'b0, 32'd24};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd24};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd28};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd32};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd36};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd40};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd44};

        do_reset();
        for (int i = 0; i < 22; i++)
            row($sformatf("stream c%0d", i), tbl[i].stall, tbl[i].gnt, tbl[i].rsp,
                1'b0, 32'h0, tbl[i].ev, tbl[i].epc, tbl[i].er, tbl[i].ea);

        // two in flight at flush -> both dropped, target aligned to 0x100
        do_reset();
        row("flush2 c0", 0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
        row("flush2 c1", 0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        row("flush2 c2", 0, 1, 0, 1, 32'h103, 0, 32'h0,   1, 32'h4);
        row("flush2 c3", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h100);
        row("flush2 c4", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h104);
        row("flush2 c5", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h108);
        row("flush2 c6", 0, 1, 1, 0, 32'h0,   1, 32'h100, 1, 32'h10C);
        row("flush2 c7", 0, 1, 1, 0, 32'h0,   1, 32'h104, 1, 32'h110);

        // flush while a request waits for grant: address held, response dropped
        do_reset();
        row("pend c0", 0, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0);
        row("pend c1", 0, 0, 1, 1, 32'h200, 0, 32'h0,   1, 32'h0);
        row("pend c2", 0, 0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        row("pend c3", 0, 0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        row("pend c4", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        row("pend c5", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h200);
        row("pend c6", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h204);
        row("pend c7", 0, 1, 1, 0, 32'h0,   1, 32'h200, 1, 32'h208);

        // flush, pop and rvalid together
        do_reset();
        row("fpr c0", 0, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0);
        row("fpr c1", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        row("fpr c2", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h4);
        row("fpr c3", 0, 1, 1, 1, 32'h300, 1, 32'h0,   1, 32'h8);
        row("fpr c4", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h300);
        row("fpr c5", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h304);
        row("fpr c6", 0, 1, 1, 0, 32'h0,   1, 32'h300, 1, 32'h308);
        row("fpr c7", 0, 1, 1, 0, 32'h0,   1, 32'h304, 1, 32'h30C);

        // address wrap at the top of memory
        do_reset();
        row("wrap c0", 0, 1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,         0, 32'h0);
        row("wrap c1", 0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFF8);
        row("wrap c2", 0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC);
        row("wrap c3", 0, 1, 1, 0, 32'h0,         1, 32'hFFFF_FFF8, 1, 32'h0);
        row("wrap c4", 0, 1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h4);
        row("wrap c5", 0, 1, 1, 0, 32'h0,         1, 32'h0,         1, 32'h8);

        // back-to-back flushes: last target wins
        do_reset();
        row("b2b c0", 0, 0, 1, 1, 32'h400, 0, 32'h0,   0, 32'h0);
        row("b2b c1", 0, 0, 1, 1, 32'h500, 0, 32'h0,   1, 32'h400);
        row("b2b c2", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h400);
        row("b2b c3", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h500);
        row("b2b c4", 0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h504);
        row("b2b c5", 0, 1, 1, 0, 32'h0,   1, 32'h500, 1, 32'h508);

        // asynchronous reset in the middle of a cycle
        #3;
        rstn = 1'b0;
        #1;
        check("async reset", 1'b0, 32'h0, 1'b0, 32'h0);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
